// File: rtl/scrub_pkg.sv
// scrub_pkg: shared FSM states, zero fill constant and count-width helper for scrub_fifo
package scrub_pkg;
  typedef enum logic [1:0] {IDLE, SCRUB, VERIFY} state_t;
  localparam bit ZERO_FILL = 1'b0;
  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/scrub_mem.sv
// scrub_mem: DEPTH x WIDTH slot array with push write, zero-select write, head read and scrub/verify read
module scrub_mem import scrub_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             zr,
  input  logic [AW-1:0]    zaddr,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0]    vaddr,
  output logic [WIDTH-1:0] vdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // zeroing wins over a push; the top never aims both at one slot in a cycle
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (rst || (zr && zaddr == AW'(i))) mem[i] <= {WIDTH{ZERO_FILL}};
      else if (we && waddr == AW'(i)) mem[i] <= wdata;
  assign rdata = mem[raddr];
  assign vdata = mem[vaddr];
endmodule

// File: rtl/scrub_fifo.sv
// scrub_fifo: valid/ready FIFO that zeroizes slots on pop, flush and reset.
// Define SCRUB_VERIFY_EN to add a post-scrub VERIFY pass driving a sticky scrub_err.
module scrub_fifo import scrub_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             scrub_busy,
  output logic [CW-1:0]    count,
  output logic             scrub_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr, idx;
  logic [WIDTH-1:0] mem_rd, vdata;
  logic idle, last, push, pop;
  assign idle = state == IDLE;
  assign last = idx == AW'(DEPTH - 1);
  assign wr_ready = idle && count < CW'(DEPTH);
  assign rd_valid = idle && count != '0;
  assign push = wr_valid && wr_ready && !flush;
  assign pop = rd_valid && rd_ready && !flush;
  assign rd_data = rd_valid ? mem_rd : '0;
  assign scrub_busy = !idle;
  always_comb begin
    state_n = state;
`ifdef SCRUB_VERIFY_EN
    state_n = idle ? (flush ? SCRUB : IDLE) :
              state == SCRUB ? (last ? VERIFY : SCRUB) : (last ? IDLE : VERIFY);
`else
    state_n = idle ? (flush ? SCRUB : IDLE) : (last ? IDLE : SCRUB);
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (idle && flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        idx <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        idx <= idle ? '0 : idx + AW'(1);
      end
    end
`ifdef SCRUB_VERIFY_EN
  always_ff @(posedge clk)
    if (rst) scrub_err <= 1'b0;
    else if (state == VERIFY && vdata != '0) scrub_err <= 1'b1;
`else
  logic unused_vdata;
  assign unused_vdata = ^vdata;
  assign scrub_err = 1'b0;
`endif
  scrub_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(push),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .zr(pop || state == SCRUB),
    .zaddr(idle ? rd_ptr : idx),
    .raddr(rd_ptr),
    .rdata(mem_rd),
    .vaddr(idx),
    .vdata(vdata)
  );
endmodule
